// File: rtl/collision_probe.sv
// Collision-ROM read client: issues 8 edge probes (9 with COLLISION_CENTER_PROBE_EN) around the player box,
// one read per clock, and reports per-edge blocking plus a touched-code mask; done 10 (11) clocks after start.
module collision_probe #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int ADDR_W     = 19,
  parameter int CODE_W     = 3,
  parameter int BOX_W      = 16,
  parameter int BOX_H      = 24,
  parameter int SOLID_CODE = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [9:0]              pos_x,
  input  logic [9:0]              pos_y,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [CODE_W-1:0]       rom_q,
  output logic                    busy,
  output logic                    done,
  output logic                    blocked_up,
  output logic                    blocked_down,
  output logic                    blocked_left,
  output logic                    blocked_right,
  output logic [(1<<CODE_W)-1:0]  hit_mask,
  output logic [CODE_W-1:0]       center_code
);

`ifdef COLLISION_CENTER_PROBE_EN
  localparam int NPROBE = 9;
`else
  localparam int NPROBE = 8;
`endif
  localparam int IDX_W  = 4;
  localparam int MASK_W = 1 << CODE_W;

  localparam logic signed [11:0] BW12   = 12'(BOX_W);
  localparam logic signed [11:0] BH12   = 12'(BOX_H);
  localparam logic signed [11:0] SW12   = 12'(SCREEN_W);
  localparam logic signed [11:0] SH12   = 12'(SCREEN_H);
  localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(SCREEN_W);
  localparam logic [CODE_W-1:0]  SOLID  = CODE_W'(SOLID_CODE);
  localparam logic [IDX_W-1:0]   LAST   = IDX_W'(NPROBE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q;
  logic [9:0]          x_q, y_q;
  logic [IDX_W-1:0]    idx_q;
  logic                s0_vld_q, s0_oob_q, s1_vld_q, s1_oob_q;
  logic [IDX_W-1:0]    s0_idx_q, s1_idx_q;
  logic                acc_up_q, acc_dn_q, acc_lf_q, acc_rt_q;
  logic [MASK_W-1:0]   acc_mask_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                busy_q, done_q;
  logic                up_q, dn_q, lf_q, rt_q;
  logic [MASK_W-1:0]   mask_q;

  logic [IDX_W-1:0]    issue_idx_d;
  logic signed [11:0]  bx_d, by_d, px_d, py_d;
  logic                oob_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [CODE_W-1:0]   code_d;
  logic                solid_d, last_d;
  logic                up_d, dn_d, lf_d, rt_d;
  logic [MASK_W-1:0]   mask_d;

  // In IDLE the first probe is computed straight from the start-cycle position.
  always_comb begin
    issue_idx_d = (state_q == IDLE) ? '0 : idx_q;
    bx_d = (state_q == IDLE) ? $signed({2'b00, pos_x}) : $signed({2'b00, x_q});
    by_d = (state_q == IDLE) ? $signed({2'b00, pos_y}) : $signed({2'b00, y_q});
    px_d = bx_d;
    py_d = by_d;
    case (issue_idx_d)
      4'd0:    begin px_d = bx_d + 12'sd1;        py_d = by_d - 12'sd1;        end
      4'd1:    begin px_d = bx_d + BW12 - 12'sd2; py_d = by_d - 12'sd1;        end
      4'd2:    begin px_d = bx_d + 12'sd1;        py_d = by_d + BH12;          end
      4'd3:    begin px_d = bx_d + BW12 - 12'sd2; py_d = by_d + BH12;          end
      4'd4:    begin px_d = bx_d - 12'sd1;        py_d = by_d + 12'sd1;        end
      4'd5:    begin px_d = bx_d - 12'sd1;        py_d = by_d + BH12 - 12'sd2; end
      4'd6:    begin px_d = bx_d + BW12;          py_d = by_d + 12'sd1;        end
      4'd7:    begin px_d = bx_d + BW12;          py_d = by_d + BH12 - 12'sd2; end
      default: begin px_d = bx_d + (BW12 >>> 1);  py_d = by_d + (BH12 >>> 1);  end
    endcase
    oob_d  = (px_d < 12'sd0) || (px_d >= SW12) || (py_d < 12'sd0) || (py_d >= SH12);
    addr_d = oob_d ? '0 : (ADDR_W'(py_d[9:0]) * STRIDE + ADDR_W'(px_d[9:0]));

    code_d  = s1_oob_q ? SOLID : rom_q;
    solid_d = (code_d == SOLID);
    last_d  = (s1_idx_q == LAST);
    up_d    = acc_up_q | (solid_d && s1_idx_q[3:1] == 3'd0);
    dn_d    = acc_dn_q | (solid_d && s1_idx_q[3:1] == 3'd1);
    lf_d    = acc_lf_q | (solid_d && s1_idx_q[3:1] == 3'd2);
    rt_d    = acc_rt_q | (solid_d && s1_idx_q[3:1] == 3'd3);
    mask_d  = acc_mask_q | (MASK_W'(1) << code_d);
  end

`ifdef COLLISION_CENTER_PROBE_EN
  logic [CODE_W-1:0] center_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      center_q <= '0;
    end else if (s1_vld_q && last_d) begin
      center_q <= code_d;
    end
  end
  assign center_code = center_q;
`else
  assign center_code = '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      s0_vld_q   <= 1'b0;
      s0_oob_q   <= 1'b0;
      s0_idx_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_oob_q   <= 1'b0;
      s1_idx_q   <= '0;
      acc_up_q   <= 1'b0;
      acc_dn_q   <= 1'b0;
      acc_lf_q   <= 1'b0;
      acc_rt_q   <= 1'b0;
      acc_mask_q <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      lf_q       <= 1'b0;
      rt_q       <= 1'b0;
      mask_q     <= '0;
    end else begin
      done_q   <= 1'b0;
      s0_vld_q <= 1'b0;
      s1_vld_q <= s0_vld_q;
      s1_oob_q <= s0_oob_q;
      s1_idx_q <= s0_idx_q;

      case (state_q)
        IDLE: begin
          if (start) begin
            x_q        <= pos_x;
            y_q        <= pos_y;
            rom_addr_q <= addr_d;
            s0_vld_q   <= 1'b1;
            s0_oob_q   <= oob_d;
            s0_idx_q   <= issue_idx_d;
            idx_q      <= IDX_W'(1);
            busy_q     <= 1'b1;
            acc_up_q   <= 1'b0;
            acc_dn_q   <= 1'b0;
            acc_lf_q   <= 1'b0;
            acc_rt_q   <= 1'b0;
            acc_mask_q <= '0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          rom_addr_q <= addr_d;
          s0_vld_q   <= 1'b1;
          s0_oob_q   <= oob_d;
          s0_idx_q   <= issue_idx_d;
          idx_q      <= idx_q + IDX_W'(1);
          if (idx_q == LAST) state_q <= DRAIN;
        end
        default: ;
      endcase

      // Results arrive two clocks after issue; the last one publishes and ends the scan.
      if (s1_vld_q) begin
        acc_up_q   <= up_d;
        acc_dn_q   <= dn_d;
        acc_lf_q   <= lf_d;
        acc_rt_q   <= rt_d;
        acc_mask_q <= mask_d;
        if (last_d) begin
          up_q    <= up_d;
          dn_q    <= dn_d;
          lf_q    <= lf_d;
          rt_q    <= rt_d;
          mask_q  <= mask_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end

  assign rom_addr      = rom_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign blocked_up    = up_q;
  assign blocked_down  = dn_q;
  assign blocked_left  = lf_q;
  assign blocked_right = rt_q;
  assign hit_mask      = mask_q;

endmodule

// File: tb/tb_collision_probe.sv
module tb_collision_probe;

`ifdef COLLISION_CENTER_PROBE_EN
  localparam int NP  = 9;
  localparam int LAT = 11;
`else
  localparam int NP  = 8;
  localparam int LAT = 10;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  pos_x, pos_y;
  logic [18:0] rom_addr;
  logic [2:0]  rom_q = 3'd0;
  logic        busy, done;
  logic        blocked_up, blocked_down, blocked_left, blocked_right;
  logic [7:0]  hit_mask;
  logic [2:0]  center_code;

  collision_probe dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .rom_addr(rom_addr), .rom_q(rom_q), .busy(busy), .done(done),
    .blocked_up(blocked_up), .blocked_down(blocked_down), .blocked_left(blocked_left),
    .blocked_right(blocked_right), .hit_mask(hit_mask), .center_code(center_code)
  );

  always #5 clock = ~clock;

  // ROM model: background fill, one special row, optional center marker at (108,112).
  int fill = 0, row_y = -1, row_code = 0;
  bit cen_en = 0;
  always @(posedge clock) begin
    int a, x, y, c;
    a = int'(rom_addr);
    x = a % 640;
    y = a / 640;
    c = fill;
    if (y == row_y) c = row_code;
    if (cen_en && x == 108 && y == 112) c = 4;
    rom_q <= 3'(c);
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {bit up; bit dn; bit lf; bit rt; int mask; int cen; int t;} exp_t;
  exp_t exp_q[$];
  int   addr_q[$];
  int   total = 0, bad = 0;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Result monitor: every done pulse must match the oldest outstanding scan.
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1, expected no scan pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("blocked_up",    int'(blocked_up),    int'(e.up));
        check("blocked_down",  int'(blocked_down),  int'(e.dn));
        check("blocked_left",  int'(blocked_left),  int'(e.lf));
        check("blocked_right", int'(blocked_right), int'(e.rt));
        check("hit_mask",      int'(hit_mask),      e.mask);
        check("center_code",   int'(center_code),   e.cen);
        check("latency",       cyc - e.t,           LAT);
      end
    end
  end

  // Address monitor: first NP busy cycles of a scan carry the probe addresses.
  int bcnt = 0;
  always @(negedge clock) begin
    if (!reset_n || !busy) begin
      bcnt = 0;
    end else begin
      if (bcnt < NP && addr_q.size() > 0) check("rom_addr", int'(rom_addr), addr_q.pop_front());
      bcnt++;
    end
  end

  task automatic do_start(input int x, input int y, input bit push,
                          input bit up, input bit dn, input bit lf, input bit rt,
                          input int mask, input int cen);
    exp_t e;
    pos_x = 10'(x);
    pos_y = 10'(y);
    start = 1'b1;
    e = '{up, dn, lf, rt, mask, cen, cyc};
    if (push) exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    pos_x = 10'(x + 37);
    pos_y = 10'(y + 5);
  endtask

  task automatic wait_done;
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clock);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done, expected done within 40 cycles");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    pos_x   = '0;
    pos_y   = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(rom_addr), 0);
    check("rst_up",   int'(blocked_up), 0);
    check("rst_down", int'(blocked_down), 0);
    check("rst_left", int'(blocked_left), 0);
    check("rst_right", int'(blocked_right), 0);
    check("rst_mask", int'(hit_mask), 0);
    check("rst_center", int'(center_code), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_busy", int'(busy), 0);
    check("idle_addr", int'(rom_addr), 0);

    // Free space, with address sequence
    addr_q = '{63461, 63474, 79461, 79474, 64739, 78179, 64756, 78196};
`ifdef COLLISION_CENTER_PROBE_EN
    addr_q.push_back(71788);
`endif
    do_start(100, 100, 1, 0, 0, 0, 0, 8'h01, 0);
    check("busy_mid", int'(busy), 1);
    wait_done();
    @(negedge clock);
    check("busy_after", int'(busy), 0);

    // Floor, then two back-to-back hazard scans started in the done cycle
    row_y = 124; row_code = 1;
    do_start(100, 100, 1, 0, 1, 0, 0, 8'h03, 0);
    wait_done();
    row_code = 3;
    do_start(100, 100, 1, 0, 0, 0, 0, 8'h09, 0);
    wait_done();
    row_code = 2;
    do_start(100, 100, 1, 0, 0, 0, 0, 8'h05, 0);
    wait_done();
    repeat (4) @(negedge clock);
    check("hold_mask", int'(hit_mask), 8'h05);

    // Screen bounds
    row_y = -1;
    do_start(0, 0, 1, 1, 0, 1, 0, 8'h03, 0);
    wait_done();
    @(negedge clock);
    do_start(624, 456, 1, 0, 1, 0, 1, 8'h03, 0);
    wait_done();
    @(negedge clock);

    // Start while busy is ignored
    row_y = 124; row_code = 1;
    do_start(100, 100, 1, 0, 1, 0, 0, 8'h03, 0);
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    repeat (15) @(negedge clock);

    // Reset mid-scan aborts without a done pulse
    do_start(100, 100, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_mask", int'(hit_mask), 0);
    check("abort_down", int'(blocked_down), 0);
    check("abort_addr", int'(rom_addr), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (15) @(negedge clock);
    do_start(100, 100, 1, 0, 1, 0, 0, 8'h03, 0);
    wait_done();
    @(negedge clock);

`ifdef COLLISION_CENTER_PROBE_EN
    row_y = -1; cen_en = 1;
    do_start(100, 100, 1, 0, 0, 0, 0, 8'h11, 4);
    wait_done();
    @(negedge clock);
`endif

    repeat (5) @(negedge clock);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_scans: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
